// File: rtl/dmem_pkg.sv
// Shared state encoding, default widths and the parity helper for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 10;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic dmem_parity(input logic [DMEM_DATA_W-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a one-cycle read; read data holds until the next read.
module dmem_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one core request, waits WAIT_CYCLES, accesses the RAM, then acks.
// Build option: define DMEM_PARITY_EN to store an even-parity bit per word and flag read faults.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              d_r,
    input  logic              d_w,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] ddata_w,
    output logic [DATA_W-1:0] ddata_r,
    output logic              ack,
    output logic              stall,
    output logic              err
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
    localparam int unsigned RAM_W = DATA_W + 1;
`else
    localparam int unsigned RAM_W = DATA_W;
`endif

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [DMEM_CNT_W-1:0] w_cnt_nxt;
    logic                  w_accept;

    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_op_wr;
    logic                  r_collide;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_rd_zero;

    logic                  w_oor;
    logic                  w_ram_en;
    logic [RAM_W-1:0]      w_ram_wdata;
    logic [RAM_W-1:0]      w_ram_rdata;

    assign w_oor = 32'(r_addr) >= DEPTH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_r | d_w) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = DMEM_CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - DMEM_CNT_W'(1);
                end
            end
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_rd_zero masks the RAM output after reset and for out-of-range reads; it only moves on reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op_wr   <= 1'b0;
            r_collide <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            if (w_accept) begin
                r_addr    <= daddr;
                r_wdata   <= ddata_w;
                r_op_wr   <= d_w;
                r_collide <= d_r & d_w;
            end
            r_ack <= (r_state == ACCESS);
            r_err <= (r_state == ACCESS) & (r_collide | w_oor);
            if ((r_state == ACCESS) && !r_op_wr) begin
                r_rd_zero <= w_oor;
            end
        end
    end

    assign w_ram_en = (r_state == ACCESS) & ~w_oor;

`ifdef DMEM_PARITY_EN
    logic w_par_err;
    assign w_ram_wdata = {dmem_parity(DMEM_DATA_W'(r_wdata)), r_wdata};
    assign w_par_err   = r_ack & ~r_op_wr & ~r_rd_zero &
                         (dmem_parity(DMEM_DATA_W'(w_ram_rdata[DATA_W-1:0])) != w_ram_rdata[DATA_W]);
    assign err         = r_err | w_par_err;
`else
    assign w_ram_wdata = r_wdata;
    assign err         = r_err;
`endif

    dmem_ram #(
        .ADDR_W (RAM_AW),
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_en    (w_ram_en),
        .i_we    (r_op_wr),
        .i_addr  (r_addr[RAM_AW-1:0]),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign ddata_r = r_rd_zero ? '0 : w_ram_rdata[DATA_W-1:0];
    assign ack     = r_ack;
    assign stall   = (d_r | d_w) & ~r_ack;

endmodule
